pc_flow_unit: RTL and testbench
===============================

Name: pc_flow_unit

Overview:
- Program-counter and flow-control stage that consumes the ALU ZERO flag plus the decoder's jump/branch controls and produces the next PC.
- Runs a two-state fetch/execute handshake with instruction memory.
- Honours a data-memory BUSYWAIT stall.
- Counts retired instructions.

Parameters:
- PC_WIDTH, 32, width of PC and target arithmetic
- RESET_PC, 0, PC value loaded on reset
- CNT_WIDTH, 16, width of retired-instruction counter

Ports:
- CLK  input  1  processor clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted)
- INSTR_READY  input  1  instruction memory has valid instruction for current PC
- JUMP  input  1  decoder: unconditional jump
- BRANCH  input  1  decoder: beq (taken when ZERO=1)
- BRANCH_NE  input  1  decoder: bne (taken when ZERO=0)
- ZERO  input  1  ALU zero flag (ADD/SUB result == 0)
- OFFSET  input  8  signed word offset from instruction
- BUSYWAIT  input  1  data memory stall; holds retirement
- PC  output  PC_WIDTH  current instruction address
- INSTR_READ  output  1  fetch request to instruction memory
- FLOW_TAKEN  output  1  one-cycle pulse: retired instruction redirected PC
- FLOW_ERR  output  1  one-cycle pulse: BRANCH and BRANCH_NE both high at retirement
- RETIRED  output  CNT_WIDTH  retired-instruction count

Behaviour:
- States: IDLE, FETCH, EXEC. Registered state; outputs are Moore except FLOW_TAKEN/FLOW_ERR, which are registered pulses.
- Reset (RESET=0, async, any time, including mid-fetch or mid-stall):
  - PC=RESET_PC, state=IDLE, INSTR_READ=0, FLOW_TAKEN=0, FLOW_ERR=0, RETIRED=0.
  - Held for as long as RESET=0.
- IDLE: first rising edge with RESET=1 moves to FETCH. PC unchanged.
- FETCH:
  - INSTR_READ=1.
  - At a rising edge with INSTR_READY=1: go to EXEC.
  - Otherwise stay in FETCH; no limit on wait cycles.
- EXEC:
  - INSTR_READ=0.
  - At a rising edge with BUSYWAIT=1: stay in EXEC; PC, RETIRED and pulses unchanged/low.
  - At a rising edge with BUSYWAIT=0 (retirement): PC<=NEXT_PC, RETIRED<=RETIRED+1, go to FETCH, FLOW_TAKEN/FLOW_ERR set per the rules below for exactly one cycle.
- Fetch-to-retire latency: minimum 2 cycles per instruction (1 FETCH with INSTR_READY=1 + 1 EXEC with BUSYWAIT=0).
- NEXT_PC:
  - SEQ = PC + 4.
  - TGT = PC + 4 + (sign-extended OFFSET shifted left 2). OFFSET=8'h80 gives -512 bytes; 8'h7F gives +508.
  - Arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- Selection priority:
  - JUMP=1 -> TGT, taken.
  - Else BRANCH=1 and BRANCH_NE=1 -> SEQ, not taken, FLOW_ERR=1.
  - Else BRANCH=1 and ZERO=1 -> TGT, taken.
  - Else BRANCH_NE=1 and ZERO=0 -> TGT, taken.
  - Else SEQ.
  - When JUMP is high, FLOW_ERR is suppressed even if both branch flags are high.
- Control inputs (JUMP, BRANCH, BRANCH_NE, ZERO, OFFSET) are sampled only at the retiring edge. Values in other cycles are ignored.
- Timing model:
  - PC register output changes #1 after the edge.
  - SEQ adder #1, TGT adder #2.
  - ZERO from the ALU arrives up to #2 after its operands settle. All inputs must be stable before the retiring edge.
- RETIRED wraps from all-ones to 0.
- INSTR_READY while not in FETCH: ignored.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'b00, FETCH=2'b01, EXEC=2'b10
  - PC_INC=4
  - OFFSET_SHIFT=2
- One sub-module: pc_target_adder, combinational. Computes SEQ and TGT from PC and OFFSET with the #1/#2 delays.
- FSM, selection logic and counters live in pc_flow_unit.

Test Plan:
- Reset:
  - Stimulus: RESET=0 for 3 cycles, then 1; INSTR_READY=1, BUSYWAIT=0, no flow controls.
  - Required: PC=0 and INSTR_READ=0 during reset. INSTR_READ=1 one edge after release. PC steps 0->4->8 every 2 cycles; RETIRED=1,2.
- Branch taken/not taken:
  - Stimulus: at PC=8, BRANCH=1, ZERO=1, OFFSET=8'h03.
  - Required: PC=24, FLOW_TAKEN pulse.
  - Repeat with ZERO=0: PC=12, no pulse.
  - BRANCH_NE=1, ZERO=0, OFFSET=8'hFE at PC=20: PC=16.
- Stall:
  - Stimulus: EXEC at PC=4 with BUSYWAIT=1 for 4 cycles.
  - Required: PC stays 4, RETIRED unchanged, INSTR_READ=0. After release, PC=8 on the next edge.
- Fetch wait + priority:
  - Stimulus: INSTR_READY=0 for 5 cycles; then JUMP=1, BRANCH=1, BRANCH_NE=1, OFFSET=8'h80 at PC=1024.
  - Required: INSTR_READ held high for all 5 cycles. PC=516, FLOW_TAKEN=1, FLOW_ERR=0.
- Error + wrap:
  - Stimulus: BRANCH=BRANCH_NE=1, JUMP=0 at PC=32'hFFFF_FFFC.
  - Required: PC=0 (wrap), FLOW_ERR pulse, FLOW_TAKEN=0.
- Async reset mid-stall:
  - Stimulus: RESET=0 between edges while in EXEC with BUSYWAIT=1.
  - Required: PC=RESET_PC, INSTR_READ=0, RETIRED=0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/pc_flow_unit_pkg.sv
// Shared encodings and constants for the PC / flow-control stage.
package pc_flow_unit_pkg;

   // Fetch/execute handshake states (encodings fixed for debug visibility).
   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StFetch = 2'b01,
      StExec  = 2'b10
   } state_e;

   // Byte increment between sequential instructions.
   localparam int unsigned PC_INC = 4;

   // Branch/jump offsets are in words; shift converts to bytes.
   localparam int unsigned OFFSET_SHIFT = 2;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-address adders: sequential PC and PC-relative target.
module pc_target_adder
   import pc_flow_unit_pkg::*;
#(
   parameter int unsigned PC_WIDTH = 32
) (
   input  logic [PC_WIDTH-1:0] pc_i,
   input  logic [7:0]          offset_i,
   output logic [PC_WIDTH-1:0] seq_o,
   output logic [PC_WIDTH-1:0] tgt_o
);

   logic [PC_WIDTH-1:0] off_ext;
   logic [PC_WIDTH-1:0] off_bytes;

   // Sign-extend the word offset, scale to bytes, add to PC+4 (modulo 2^PC_WIDTH).
   always_comb begin
      off_ext   = {{(PC_WIDTH-8){offset_i[7]}}, offset_i};
      off_bytes = off_ext << OFFSET_SHIFT;
      seq_o     = pc_i + PC_WIDTH'(PC_INC);
      tgt_o     = seq_o + off_bytes;
   end

endmodule

// File: rtl/pc_flow_unit.sv
// Program counter with fetch/execute handshake, branch/jump selection,
// data-memory stall and retired-instruction counter.
module pc_flow_unit
   import pc_flow_unit_pkg::*;
#(
   parameter int unsigned         PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int unsigned         CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 INSTR_READY,
   input  logic                 JUMP,
   input  logic                 BRANCH,
   input  logic                 BRANCH_NE,
   input  logic                 ZERO,
   input  logic [7:0]           OFFSET,
   input  logic                 BUSYWAIT,
   output logic [PC_WIDTH-1:0]  PC,
   output logic                 INSTR_READ,
   output logic                 FLOW_TAKEN,
   output logic                 FLOW_ERR,
   output logic [CNT_WIDTH-1:0] RETIRED
);

   state_e               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;
   logic                 flow_taken_q, flow_taken_d;
   logic                 flow_err_q, flow_err_d;

   logic [PC_WIDTH-1:0]  seq_pc;
   logic [PC_WIDTH-1:0]  tgt_pc;
   logic                 take;
   logic                 conflict;

   pc_target_adder #(
      .PC_WIDTH (PC_WIDTH)
   ) u_adder (
      .pc_i     (pc_q),
      .offset_i (OFFSET),
      .seq_o    (seq_pc),
      .tgt_o    (tgt_pc)
   );

   // Flow decision; JUMP outranks the beq/bne conflict so no error is flagged under it.
   always_comb begin
      take     = 1'b0;
      conflict = 1'b0;
      if (JUMP) begin
         take = 1'b1;
      end else if (BRANCH && BRANCH_NE) begin
         conflict = 1'b1;
      end else if (BRANCH && ZERO) begin
         take = 1'b1;
      end else if (BRANCH_NE && !ZERO) begin
         take = 1'b1;
      end
   end

   // Next-state: handshake FSM, PC update and counter advance only at retirement.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      retired_d    = retired_q;
      flow_taken_d = 1'b0;
      flow_err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (INSTR_READY) begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (!BUSYWAIT) begin
               state_d      = StFetch;
               pc_d         = take ? tgt_pc : seq_pc;
               retired_d    = retired_q + CNT_WIDTH'(1);
               flow_taken_d = take;
               flow_err_d   = conflict;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         retired_q    <= '0;
         flow_taken_q <= 1'b0;
         flow_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         retired_q    <= retired_d;
         flow_taken_q <= flow_taken_d;
         flow_err_q   <= flow_err_d;
      end
   end

   // Moore outputs and registered pulses.
   always_comb begin
      PC         = pc_q;
      INSTR_READ = (state_q == StFetch);
      FLOW_TAKEN = flow_taken_q;
      FLOW_ERR   = flow_err_q;
      RETIRED    = retired_q;
   end

endmodule

// File: tb/tb_pc_flow_unit.sv
// Directed self-checking bench for pc_flow_unit.
module tb_pc_flow_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        INSTR_READY;
   logic        JUMP;
   logic        BRANCH;
   logic        BRANCH_NE;
   logic        ZERO;
   logic [7:0]  OFFSET;
   logic        BUSYWAIT;
   logic [31:0] PC;
   logic        INSTR_READ;
   logic        FLOW_TAKEN;
   logic        FLOW_ERR;
   logic [15:0] RETIRED;

   int errors = 0;
   int checks = 0;

   pc_flow_unit #(
      .PC_WIDTH  (32),
      .RESET_PC  (32'h0),
      .CNT_WIDTH (16)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .INSTR_READY (INSTR_READY),
      .JUMP        (JUMP),
      .BRANCH      (BRANCH),
      .BRANCH_NE   (BRANCH_NE),
      .ZERO        (ZERO),
      .OFFSET      (OFFSET),
      .BUSYWAIT    (BUSYWAIT),
      .PC          (PC),
      .INSTR_READ  (INSTR_READ),
      .FLOW_TAKEN  (FLOW_TAKEN),
      .FLOW_ERR    (FLOW_ERR),
      .RETIRED     (RETIRED)
   );

   always #5 CLK = ~CLK;

   task automatic clear_ctrl();
      JUMP      = 1'b0;
      BRANCH    = 1'b0;
      BRANCH_NE = 1'b0;
      ZERO      = 1'b0;
      OFFSET    = 8'h00;
   endtask

   // Reset, release, and leave the DUT in FETCH at RESET_PC.
   task automatic reset_dut();
      clear_ctrl();
      INSTR_READY = 1'b1;
      BUSYWAIT    = 1'b0;
      RESET       = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   // One full instruction from FETCH: present controls, fetch, then retire.
   task automatic do_instr(input logic j, input logic b, input logic bn, input logic z,
                           input logic [7:0] off);
      JUMP        = j;
      BRANCH      = b;
      BRANCH_NE   = bn;
      ZERO        = z;
      OFFSET      = off;
      INSTR_READY = 1'b1;
      BUSYWAIT    = 1'b0;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      clear_ctrl();
   endtask

   task automatic test_reset();
      clear_ctrl();
      INSTR_READY = 1'b1;
      BUSYWAIT    = 1'b0;
      RESET       = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         checks++;
         if (PC !== 32'h0 || INSTR_READ !== 1'b0 || RETIRED !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: PC=%h READ=%b RET=%0d, want 0/0/0", PC, INSTR_READ, RETIRED);
         end
      end
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      checks++;
      if (INSTR_READ !== 1'b1 || PC !== 32'h0) begin
         errors++;
         $display("FAIL reset_release: READ=%b PC=%h, want 1/0", INSTR_READ, PC);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (INSTR_READ !== 1'b0 || PC !== 32'h0) begin
         errors++;
         $display("FAIL reset_exec: READ=%b PC=%h, want 0/0", INSTR_READ, PC);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (PC !== 32'h4 || RETIRED !== 16'd1 || INSTR_READ !== 1'b1) begin
         errors++;
         $display("FAIL seq_1: PC=%h RET=%0d READ=%b, want 4/1/1", PC, RETIRED, INSTR_READ);
      end
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (PC !== 32'h8 || RETIRED !== 16'd2 || FLOW_TAKEN !== 1'b0) begin
         errors++;
         $display("FAIL seq_2: PC=%h RET=%0d TAKEN=%b, want 8/2/0", PC, RETIRED, FLOW_TAKEN);
      end
   endtask

   // Continues from PC=8 in FETCH.
   task automatic test_branch();
      do_instr(1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
      checks++;
      if (PC !== 32'd12 || FLOW_TAKEN !== 1'b0) begin
         errors++;
         $display("FAIL beq_not_taken: PC=%0d TAKEN=%b, want 12/0", PC, FLOW_TAKEN);
      end
      do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
      checks++;
      if (PC !== 32'd8 || FLOW_TAKEN !== 1'b1) begin
         errors++;
         $display("FAIL jump_back: PC=%0d TAKEN=%b, want 8/1", PC, FLOW_TAKEN);
      end
      do_instr(1'b0, 1'b1, 1'b0, 1'b1, 8'h03);
      checks++;
      if (PC !== 32'd24 || FLOW_TAKEN !== 1'b1 || FLOW_ERR !== 1'b0) begin
         errors++;
         $display("FAIL beq_taken: PC=%0d TAKEN=%b ERR=%b, want 24/1/0", PC, FLOW_TAKEN, FLOW_ERR);
      end
      do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
      do_instr(1'b0, 1'b0, 1'b1, 1'b0, 8'hFE);
      checks++;
      if (PC !== 32'd16 || FLOW_TAKEN !== 1'b1) begin
         errors++;
         $display("FAIL bne_taken: PC=%0d TAKEN=%b, want 16/1", PC, FLOW_TAKEN);
      end
      do_instr(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
      checks++;
      if (PC !== 32'd20 || FLOW_TAKEN !== 1'b0) begin
         errors++;
         $display("FAIL bne_not_taken: PC=%0d TAKEN=%b, want 20/0", PC, FLOW_TAKEN);
      end
   endtask

   task automatic test_stall();
      reset_dut();
      do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      INSTR_READY = 1'b1;
      BUSYWAIT    = 1'b1;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         checks++;
         if (PC !== 32'h4 || RETIRED !== 16'd1 || INSTR_READ !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: PC=%h RET=%0d READ=%b, want 4/1/0",
                     i, PC, RETIRED, INSTR_READ);
         end
      end
      BUSYWAIT = 1'b0;
      @(posedge CLK);
      #1;
      checks++;
      if (PC !== 32'h8 || RETIRED !== 16'd2) begin
         errors++;
         $display("FAIL stall_release: PC=%h RET=%0d, want 8/2", PC, RETIRED);
      end
   endtask

   task automatic test_fetch_wait_priority();
      reset_dut();
      do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h7F);
      checks++;
      if (PC !== 32'd512) begin
         errors++;
         $display("FAIL jump_max: PC=%0d, want 512", PC);
      end
      do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h7F);
      INSTR_READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         #1;
         checks++;
         if (INSTR_READ !== 1'b1 || PC !== 32'd1024) begin
            errors++;
            $display("FAIL fetch_wait[%0d]: READ=%b PC=%0d, want 1/1024", i, INSTR_READ, PC);
         end
      end
      do_instr(1'b1, 1'b1, 1'b1, 1'b0, 8'h80);
      checks++;
      if (PC !== 32'd516 || FLOW_TAKEN !== 1'b1 || FLOW_ERR !== 1'b0) begin
         errors++;
         $display("FAIL jump_priority: PC=%0d TAKEN=%b ERR=%b, want 516/1/0",
                  PC, FLOW_TAKEN, FLOW_ERR);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (FLOW_TAKEN !== 1'b0) begin
         errors++;
         $display("FAIL taken_pulse_width: TAKEN=%b, want 0", FLOW_TAKEN);
      end
   endtask

   task automatic test_err_wrap();
      reset_dut();
      do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
      checks++;
      if (PC !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL jump_neg: PC=%h, want fffffffc", PC);
      end
      do_instr(1'b0, 1'b1, 1'b1, 1'b1, 8'h10);
      checks++;
      if (PC !== 32'h0 || FLOW_ERR !== 1'b1 || FLOW_TAKEN !== 1'b0) begin
         errors++;
         $display("FAIL err_wrap: PC=%h ERR=%b TAKEN=%b, want 0/1/0", PC, FLOW_ERR, FLOW_TAKEN);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (FLOW_ERR !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse_width: ERR=%b, want 0", FLOW_ERR);
      end
   endtask

   task automatic test_async_reset();
      reset_dut();
      do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      INSTR_READY = 1'b1;
      BUSYWAIT    = 1'b1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #3;
      RESET = 1'b0;
      #1;
      checks++;
      if (PC !== 32'h0 || INSTR_READ !== 1'b0 || RETIRED !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: PC=%h READ=%b RET=%0d, want 0/0/0", PC, INSTR_READ, RETIRED);
      end
      BUSYWAIT = 1'b0;
      @(posedge CLK);
      #1;
      checks++;
      if (INSTR_READ !== 1'b0 || PC !== 32'h0) begin
         errors++;
         $display("FAIL reset_held: READ=%b PC=%h, want 0/0", INSTR_READ, PC);
      end
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      checks++;
      if (INSTR_READ !== 1'b1) begin
         errors++;
         $display("FAIL restart: READ=%b, want 1", INSTR_READ);
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_stall();
      test_fetch_wait_priority();
      test_err_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
